// File: rtl/grey_int_ctrl.sv
// Interrupt sequencer for the grey-statistics path: latches the frame sum, raises the pin,
// enforces a post-clear low gap and counts overruns. Optional watchdog: GREY_INT_TIMEOUT_EN.
module grey_int_ctrl #(
  parameter int GREY_SUM_WIDTH = 48,
  parameter int INT_GAP        = 4,
  parameter int TIMEOUT_WIDTH  = 24
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_interrupt_en,
  input  logic                      i_int_mask,
  input  logic                      i_stat_done,
  input  logic [GREY_SUM_WIDTH-1:0] iv_grey_sum,
  input  logic                      i_int_clr,
  output logic                      o_interrupt_pin,
  output logic [GREY_SUM_WIDTH-1:0] ov_grey_sum,
  output logic [15:0]               ov_int_cnt,
  output logic [7:0]                ov_overrun_cnt,
  output logic                      o_timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_INT, ST_GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(INT_GAP);

  generate
    if (INT_GAP < 1 || INT_GAP > 15 || TIMEOUT_WIDTH < 1) begin : g_bad_cfg
      $error("grey_int_ctrl: INT_GAP must be 1..15 and TIMEOUT_WIDTH >= 1");
    end
  endgenerate

  state_t     state;
  logic [3:0] gap_cnt;
  logic       overrun_hit;
  logic       accept;
  logic       withdraw;

  // Any completed frame outside IDLE is a dropped frame; the counter sticks at 255.
  assign overrun_hit = i_stat_done && (state != ST_IDLE) && (ov_overrun_cnt != 8'hFF);
  assign accept      = i_stat_done && i_interrupt_en && !i_int_mask;
  assign withdraw    = i_int_clr || !i_interrupt_en;

`ifdef GREY_INT_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] pend_cnt;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      gap_cnt         <= 4'd0;
      o_interrupt_pin <= 1'b0;
      ov_grey_sum     <= '0;
      ov_int_cnt      <= 16'd0;
      ov_overrun_cnt  <= 8'd0;
`ifdef GREY_INT_TIMEOUT_EN
      pend_cnt        <= '0;
      o_timeout       <= 1'b0;
`endif
    end else begin
      if (overrun_hit) ov_overrun_cnt <= ov_overrun_cnt + 8'd1;

`ifdef GREY_INT_TIMEOUT_EN
      if (i_int_clr) o_timeout <= 1'b0;
`endif

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state           <= ST_INT;
            o_interrupt_pin <= 1'b1;
            ov_grey_sum     <= iv_grey_sum;
            ov_int_cnt      <= ov_int_cnt + 16'd1;
`ifdef GREY_INT_TIMEOUT_EN
            pend_cnt        <= '0;
`endif
          end
        end

        // A clear or a disabled window withdraws the pending interrupt; both start the gap.
        ST_INT: begin
          if (withdraw) begin
            state           <= ST_GAP;
            o_interrupt_pin <= 1'b0;
            gap_cnt         <= 4'd1;
          end
`ifdef GREY_INT_TIMEOUT_EN
          else if (pend_cnt == '1) begin
            state           <= ST_GAP;
            o_interrupt_pin <= 1'b0;
            gap_cnt         <= 4'd1;
            o_timeout       <= 1'b1;
          end else begin
            pend_cnt <= pend_cnt + TIMEOUT_WIDTH'(1);
          end
`endif
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else                     gap_cnt <= gap_cnt + 4'd1;
        end

        default: begin
          state           <= ST_IDLE;
          o_interrupt_pin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/grey_int_ctrl.md
# grey_int_ctrl

Interrupt sequencer for the grey-statistics path. It sits between the AOI window selector, the grey accumulator and the firmware register bank. On each frame whose statistics window is enabled, it latches the accumulated grey sum and raises the interrupt pin. It then holds the pin until firmware clears it and enforces a minimum low gap afterwards. Frames that complete while an interrupt is pending are counted as overruns.

## Interface
- GREY_SUM_WIDTH, 48, width of accumulated grey sum from the statistics block
- INT_GAP, 4, minimum interrupt-pin low cycles after a clear (1..15)
- TIMEOUT_WIDTH, 24, width of the pending-interrupt watchdog counter (macro-dependent)
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- i_interrupt_en  in  1  per-frame window-valid level from the AOI selector; 1 = this frame's statistics are valid
- i_int_mask  in  1  firmware mask; 1 blocks new interrupts, does not cancel a pending one
- i_stat_done  in  1  single-cycle pulse: accumulator finished the frame
- iv_grey_sum  in  GREY_SUM_WIDTH  accumulated sum, valid in the i_stat_done cycle
- i_int_clr  in  1  single-cycle firmware clear pulse
- o_interrupt_pin  out  1  interrupt to firmware and back to the AOI selector's i_interrupt_pin
- ov_grey_sum  out  GREY_SUM_WIDTH  latched sum for firmware readback
- ov_int_cnt  out  16  interrupts issued, wraps 0xFFFF→0
- ov_overrun_cnt  out  8  frames dropped while pending, saturates at 255
- o_timeout  out  1  sticky watchdog flag (0 when macro absent)

## Operation
- All outputs are registered. Reset value is 0 for every output, the state is IDLE, and all counters are 0.
- States: IDLE, INT, GAP.
- IDLE
  - i_stat_done & i_interrupt_en & !i_int_mask → latch iv_grey_sum, ov_int_cnt+1, go to INT.
  - i_stat_done with the other conditions false → ignored, not an overrun.
  - i_int_clr → ignored.
- INT
  - o_interrupt_pin=1.
  - i_int_clr → GAP.
  - i_interrupt_en=0 → GAP. The pending interrupt is withdrawn because firmware disabled 2A.
  - i_stat_done → ov_overrun_cnt+1 (saturating); ov_grey_sum is unchanged.
- GAP
  - o_interrupt_pin=0.
  - A 4-bit gap counter loads on entry and counts to INT_GAP, then the block goes to IDLE.
  - i_stat_done → overrun+1.
  - i_int_clr → ignored.
- Simultaneous i_int_clr and i_stat_done in INT: the clear wins and the done is counted as an overrun.
- i_int_mask rising during INT: no effect on the pending interrupt.
- reset_n low in any state: immediate return to reset values. A mid-gap reset does not resume the gap.
- ov_grey_sum changes only on the IDLE→INT transition.

## Timing
- i_stat_done at cycle N (accepted) → ov_grey_sum valid and o_interrupt_pin=1 at N+1; ov_int_cnt updates at N+1.
- i_int_clr at cycle M → o_interrupt_pin=0 at M+1.
- GAP occupies cycles M+1 … M+INT_GAP. The block is back in IDLE at M+INT_GAP+1, and an i_stat_done in that cycle is accepted.
- i_interrupt_en falling at cycle K in INT → pin low at K+1, same gap rule as a clear.
- Minimum pin high time: 1 cycle.

## Configuration
- GREY_INT_TIMEOUT_EN defined:
  - A TIMEOUT_WIDTH-bit counter clears on entry to INT and increments each INT cycle.
  - When it reaches all-ones, the block goes to GAP (pin low next cycle) and sets o_timeout.
  - o_timeout clears on the next i_int_clr, in any state.
- Not defined:
  - No counter is generated.
  - INT persists until i_int_clr or i_interrupt_en=0.
  - o_timeout is tied to 0.

## Test plan
- Reset release, then i_interrupt_en=1 and i_stat_done at cycle 10 with iv_grey_sum=0x0000_1234_5678 → at cycle 11, pin=1, ov_grey_sum=0x0000_1234_5678, ov_int_cnt=1.
- Pending interrupt, then two further i_stat_done pulses with sum=0xFFFF → ov_overrun_cnt=2, ov_grey_sum unchanged. 300 overruns → ov_overrun_cnt=255.
- i_int_clr at cycle 20 with INT_GAP=4 → pin=0 at 21. An i_stat_done at 23 is counted as an overrun. An i_stat_done at 25 is accepted, and pin=1 at 26.
- i_int_mask=1 or i_interrupt_en=0 during i_stat_done in IDLE → pin stays 0, no counter changes. i_interrupt_en dropped during INT → pin=0 the next cycle.
- i_int_clr and i_stat_done in the same INT cycle → pin=0 next cycle, overrun+1. reset_n pulsed low mid-GAP → all outputs 0 immediately.
- With GREY_INT_TIMEOUT_EN and TIMEOUT_WIDTH=4, no clear → pin falls 16 cycles after rising and o_timeout=1; the next i_int_clr → o_timeout=0.
